// File: rtl/move_input_ctrl.sv
// Button conditioning for the game: synchronize, debounce and arbitrate four raw
// direction buttons into single-cycle, mutually exclusive move pulses.
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int MOVES_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_r,
  input  logic               btn_l,
  input  logic               btn_u,
  input  logic               btn_d,
  input  logic               lose,
  output logic               r,
  output logic               l,
  output logic               u,
  output logic               d,
  output logic               busy,
  output logic [MOVES_W-1:0] moves
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    FIRE         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MOVES_W-1:0] MOVES_SAT = {MOVES_W{1'b1}};

  // Bit 3 = right, 2 = left, 1 = up, 0 = down throughout.
  logic [3:0]       raw_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       stable_r;
  logic [CNT_W-1:0] cnt_r [4];

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       dir_r;
  logic [3:0]       dir_s;
  logic [MOVES_W-1:0] moves_r;
  logic [MOVES_W-1:0] moves_s;
  logic             busy_r;

  assign raw_s = {btn_r, btn_l, btn_u, btn_d};

  // Two-flop synchronizer plus per-button debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 4'b0000;
      sync2_r  <= 4'b0000;
      stable_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_MAX) begin
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Next-state, next-pulse and move-count logic.
  always_comb begin
    state_s = state_r;
    dir_s   = 4'b0000;
    moves_s = moves_r;
    case (state_r)
      IDLE: begin
        if (!lose && (stable_r != 4'b0000)) begin
          state_s = FIRE;
          // Fixed priority r > l > u > d when several are already stable.
          if (stable_r[3]) begin
            dir_s = 4'b1000;
          end else if (stable_r[2]) begin
            dir_s = 4'b0100;
          end else if (stable_r[1]) begin
            dir_s = 4'b0010;
          end else begin
            dir_s = 4'b0001;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FIRE: begin
        state_s = WAIT_RELEASE;
        if (moves_r != MOVES_SAT) begin
          moves_s = moves_r + MOVES_W'(1);
        end else begin
          moves_s = moves_r;
        end
      end
      WAIT_RELEASE: begin
        if (stable_r == 4'b0000) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_RELEASE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pulse, busy and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      dir_r   <= 4'b0000;
      moves_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      moves_r <= moves_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign r     = dir_r[3];
  assign l     = dir_r[2];
  assign u     = dir_r[1];
  assign d     = dir_r[0];
  assign busy  = busy_r;
  assign moves = moves_r;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Self-checking bench for move_input_ctrl: scoreboard of expected pulses (direction
// and cycle) plus a table of press patterns and a few multi-cycle sequences.
module tb_move_input_ctrl;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       lose = 1'b0;
  logic       r, l, u, d, busy;
  logic [1:0] moves;

  move_input_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3), .MOVES_W(2)) dut (
    .clk(clk), .rst(rst),
    .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
    .lose(lose),
    .r(r), .l(l), .u(u), .d(d), .busy(busy), .moves(moves)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dir;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic       pulse;
    logic [3:0] dir;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   exp_moves = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Any pulse seen must match the oldest expected pulse in both direction and cycle.
  always @(negedge clk) begin
    if ({r, l, u, d} != 4'b0000) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: got rludir=%b at cycle %0d, required none", {r, l, u, d}, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({r, l, u, d} !== e.dir || cyc != e.cyc) begin
          mismatched++;
          $display("FAIL pulse: got dir=%b cyc=%0d, required dir=%b cyc=%0d", {r, l, u, d}, cyc, e.dir, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_r, btn_l, btn_u, btn_d} = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] dir, input int at);
    exp_t e;
    e.dir = dir;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_moves = 0;
  endtask

  initial begin
    int k;
    int c;
    vecs[0] = '{btn: 4'b0101, hold: 20, pulse: 1'b1, dir: 4'b0100};
    vecs[1] = '{btn: 4'b0001, hold: 20, pulse: 1'b1, dir: 4'b0001};
    vecs[2] = '{btn: 4'b0010, hold: 3,  pulse: 1'b0, dir: 4'b0000};
    vecs[3] = '{btn: 4'b0010, hold: 4,  pulse: 1'b1, dir: 4'b0010};
    vecs[4] = '{btn: 4'b1000, hold: 20, pulse: 1'b1, dir: 4'b1000};
    vecs[5] = '{btn: 4'b1111, hold: 20, pulse: 1'b1, dir: 4'b1000};

    do_reset();
    chk("reset_pulses", {28'd0, r, l, u, d}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_moves", {30'd0, moves}, 32'd0);

    // Right held from edge k: pulse after edge k+DC+2, busy rises with it.
    k = cyc + 1;
    set_btn(4'b1000);
    push(4'b1000, k + DC + 2);
    repeat (DC + 2) tick();
    chk("busy_before_fire", {31'd0, busy}, 32'd0);
    tick();
    chk("busy_at_fire", {31'd0, busy}, 32'd1);
    tick();
    chk("busy_wait_release", {31'd0, busy}, 32'd1);
    chk("r_one_cycle", {31'd0, r}, 32'd0);
    repeat (12) tick();
    set_btn(4'b0000);
    repeat (12) tick();
    chk("first_moves", {30'd0, moves}, 32'd1);
    chk("first_idle", {31'd0, busy}, 32'd0);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      k = cyc + 1;
      set_btn(vecs[i].btn);
      if (vecs[i].pulse) push(vecs[i].dir, k + DC + 2);
      repeat (vecs[i].hold) tick();
      set_btn(4'b0000);
      repeat (12) tick();
      if (vecs[i].pulse && exp_moves != 3) exp_moves++;
      chk($sformatf("vec%0d_moves", i), {30'd0, moves}, exp_moves);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Long hold of right with up added midway: only the one right pulse.
    k = cyc + 1;
    set_btn(4'b1000);
    push(4'b1000, k + DC + 2);
    repeat (50) tick();
    set_btn(4'b1010);
    repeat (50) tick();
    set_btn(4'b0000);
    repeat (12) tick();
    chk("hold_idle", {31'd0, busy}, 32'd0);

    // lose masks a held button; it fires on the first IDLE edge after lose falls.
    lose = 1'b1;
    set_btn(4'b0001);
    repeat (20) tick();
    chk("lose_busy", {31'd0, busy}, 32'd0);
    c = cyc;
    lose = 1'b0;
    push(4'b0001, c + 1);
    repeat (3) tick();
    chk("lose_release_busy", {31'd0, busy}, 32'd1);
    set_btn(4'b0000);
    repeat (12) tick();
    chk("lose_moves_sat", {30'd0, moves}, 32'd3);

    // Reset lands on the edge that would have entered FIRE.
    k = cyc + 1;
    set_btn(4'b1000);
    repeat (DC + 2) tick();
    rst = 1'b1;
    set_btn(4'b0000);
    tick();
    chk("rst_fire_pulses", {28'd0, r, l, u, d}, 32'd0);
    chk("rst_fire_busy", {31'd0, busy}, 32'd0);
    chk("rst_fire_moves", {30'd0, moves}, 32'd0);
    rst = 1'b0;
    repeat (15) tick();
    chk("post_rst_moves", {30'd0, moves}, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
